pixel_pack_fifo: RTL and testbench

- Sits directly downstream of the data_proc accelerator.
- Consumes its 8-bit pixel_out/valid_out stream, packs 4 consecutive pixels little-endian into 32-bit words, and buffers those words in a FIFO.
- The memory-mapped wrapper or the CPU drains the FIFO one word per bus read instead of one pixel per read.
- Provides a flush for partial words at end of frame, byte-keep flags, a fill level and a sticky overflow flag. The upstream source has no backpressure, so dropped pixels must be visible.

---
 rtl/pixel_pack_pkg.sv | 26 ++
 rtl/pixel_pack_fifo_sync_fifo.sv | 64 ++++++
 rtl/pixel_pack_fifo.sv | 151 +++++++++++++++
 tb/tb_pixel_pack_fifo.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pack_pkg.sv
// Shared widths, the byte-keep type and the lanes-filled to keep-mask helper
// for the pixel packer and its word FIFO.
package pixel_pack_pkg;

    localparam int PIX_W   = 8;
    localparam int LANES   = 4;
    localparam int WORD_W  = 32;
    localparam int KEEP_W  = 4;
    localparam int ENTRY_W = 36;

    typedef logic [KEEP_W-1:0] keep_t;

    // Number of filled byte lanes (0..4) to the matching low-aligned keep mask.
    function automatic keep_t keep_for_lanes(input logic [2:0] n_filled);
        keep_t k;
        case (n_filled)
            3'd0:    k = 4'h0;
            3'd1:    k = 4'h1;
            3'd2:    k = 4'h3;
            3'd3:    k = 4'h7;
            default: k = 4'hF;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/pixel_pack_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// o_rd_data whenever the FIFO is non-empty and reads as zero when empty.
// Pop when empty and push when full (without a same-cycle pop) are never
// requested by the parent, so no guarding is done here.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    assign o_count   = r_count;
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because reads are gated by o_empty.
    always_ff @(posedge clk) begin
        if (!rst && i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_pack_fifo.sv
// Packs the 8-bit pixel stream from data_proc into little-endian 32-bit words
// (first pixel in byte 0) and buffers them in a FWFT FIFO with byte-keep flags.
//
// Handshakes: a word leaves the FIFO on a cycle where word_valid && word_ready
// are both high. pix_ready is advisory only: the upstream never stalls, so a
// pixel presented while pix_ready is low is dropped and latched in overflow.
module pixel_pack_fifo
    import pixel_pack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              flush,
    output logic [WORD_W-1:0] word_out,
    output logic [KEEP_W-1:0] word_keep,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              overflow,
    input  logic              clr_overflow
);

    // Packing state: next byte lane, bytes gathered so far (unused lanes zero).
    logic [1:0]        r_lane;
    logic [WORD_W-1:0] r_pack;
    logic              r_flush_pending;
    logic              r_overflow;

    logic               w_pop;
    logic               w_space;
    logic               w_accept;
    logic               w_drop;
    logic [WORD_W-1:0]  w_merged;
    logic [2:0]         w_fill;
    logic               w_push;
    logic               w_clear_pack;
    logic               w_set_pending;
    keep_t              w_push_keep;
    logic [ENTRY_W-1:0] w_fifo_rd;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_count;

    // A same-cycle pop frees a slot, so word_ready feeds pix_ready combinationally.
    assign w_pop     = !w_fifo_empty && word_ready;
    assign w_space   = !w_fifo_full || w_pop;
    assign pix_ready = !r_flush_pending && ((r_lane != 2'd3) || w_space);
    assign w_accept  = pix_valid && pix_ready;
    assign w_drop    = pix_valid && !pix_ready;

    // Word as it stands after this cycle's pixel, and how many lanes it fills.
    always_comb begin
        w_merged = r_pack;
        if (w_accept) begin
            w_merged[{r_lane, 3'b000} +: PIX_W] = pix_in;
        end
        w_fill = {1'b0, r_lane} + {2'b00, w_accept};
    end

    // Push decision: a pending flush has priority, then a completed word,
    // then a flush of a non-empty partial word (deferred when out of space).
    always_comb begin
        w_push        = 1'b0;
        w_clear_pack  = 1'b0;
        w_set_pending = 1'b0;
        if (r_flush_pending) begin
            if (w_space) begin
                w_push       = 1'b1;
                w_clear_pack = 1'b1;
            end
        end else if (w_fill == 3'd4) begin
            w_push       = 1'b1;
            w_clear_pack = 1'b1;
        end else if (flush && (w_fill != 3'd0)) begin
            if (w_space) begin
                w_push       = 1'b1;
                w_clear_pack = 1'b1;
            end else begin
                w_set_pending = 1'b1;
            end
        end
    end

    assign w_push_keep = keep_for_lanes(w_fill);

    // Lane counter and pack register; a push restarts the next word at lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= 2'd0;
            r_pack <= '0;
        end else if (w_clear_pack) begin
            r_lane <= 2'd0;
            r_pack <= '0;
        end else if (w_accept) begin
            r_lane <= r_lane + 2'd1;
            r_pack <= w_merged;
        end
    end

    // Deferred flush: held until the first cycle with FIFO space.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_pending <= 1'b0;
        end else if (w_set_pending) begin
            r_flush_pending <= 1'b1;
        end else if (r_flush_pending && w_space) begin
            r_flush_pending <= 1'b0;
        end
    end

    // Sticky drop flag; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({w_push_keep, w_merged}),
        .i_pop       (w_pop),
        .o_rd_data   (w_fifo_rd),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign word_out   = w_fifo_rd[WORD_W-1:0];
    assign word_keep  = w_fifo_rd[ENTRY_W-1:WORD_W];
    assign word_valid = !w_fifo_empty;
    assign count      = w_fifo_count;
    assign full       = w_fifo_full;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_pixel_pack_fifo.sv
// Bench for pixel_pack_fifo: a byte-queue/word-queue model checked every cycle
// plus literal expectations at the points of interest in each scenario.
module tb_pixel_pack_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       pix_in = 8'h00;
    logic             pix_valid = 1'b0;
    logic             pix_ready;
    logic             flush = 1'b0;
    logic [31:0]      word_out;
    logic [3:0]       word_keep;
    logic             word_valid;
    logic             word_ready = 1'b0;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             overflow;
    logic             clr_overflow = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pixel_pack_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .flush        (flush),
        .word_out     (word_out),
        .word_keep    (word_keep),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input bit v, input logic [7:0] p, input bit f,
                       input bit wr, input bit clr, input bit r);
        @(negedge clk);
        pix_valid    = v;
        pix_in       = p;
        flush        = f;
        word_ready   = wr;
        clr_overflow = clr;
        rst          = r;
    endtask

    // ---------------- model ----------------
    logic [7:0]  byte_q[$];
    logic [35:0] exp_q[$];
    bit          pend = 1'b0;
    bit          ovf  = 1'b0;
    bit          live = 1'b0;

    function automatic bit model_space();
        return (exp_q.size() < DEPTH) || (word_ready && exp_q.size() > 0);
    endfunction

    function automatic bit model_ready();
        return !pend && ((byte_q.size() != 3) || model_space());
    endfunction

    function automatic void push_gathered();
        logic [31:0] w;
        logic [3:0]  k;
        w = 32'h0;
        for (int i = 0; i < byte_q.size(); i++) begin
            w = w | (32'(byte_q[i]) << (8 * i));
        end
        k = 4'((1 << byte_q.size()) - 1);
        exp_q.push_back({k, w});
        byte_q.delete();
    endfunction

    function automatic void model_step();
        bit space, ready, acc, drop;
        if (rst) begin
            byte_q.delete();
            exp_q.delete();
            pend = 1'b0;
            ovf  = 1'b0;
            live = 1'b1;
            return;
        end
        if (!live) return;
        space = model_space();
        ready = model_ready();
        acc   = pix_valid && ready;
        drop  = pix_valid && !ready;
        if (word_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) byte_q.push_back(pix_in);
        if (pend) begin
            if (space) begin
                push_gathered();
                pend = 1'b0;
            end
        end else if (byte_q.size() == 4) begin
            push_gathered();
        end else if (flush && byte_q.size() > 0) begin
            if (space) push_gathered();
            else       pend = 1'b1;
        end
        if (drop)              ovf = 1'b1;
        else if (clr_overflow) ovf = 1'b0;
    endfunction

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [35:0] head;
        forever begin
            @(negedge clk);
            #2;
            if (live) begin
                head = (exp_q.size() > 0) ? exp_q[0] : 36'h0;
                chk("sb_word_valid", {35'h0, word_valid}, {35'h0, exp_q.size() > 0});
                chk("sb_word_out", {4'h0, word_out}, {4'h0, head[31:0]});
                chk("sb_word_keep", {32'h0, word_keep}, {32'h0, head[35:32]});
                chk("sb_count", 36'(count), 36'(exp_q.size()));
                chk("sb_full", {35'h0, full}, {35'h0, exp_q.size() == DEPTH});
                chk("sb_overflow", {35'h0, overflow}, {35'h0, ovf});
                chk("sb_pix_ready", {35'h0, pix_ready}, {35'h0, model_ready()});
            end
            model_step();
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        // reset
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        chk("rst_count", 36'(count), 36'd0);
        chk("rst_valid", {35'h0, word_valid}, 36'd0);
        chk("rst_word", {4'h0, word_out}, 36'h0);
        chk("rst_ready", {35'h0, pix_ready}, 36'd1);
        chk("rst_ovf", {35'h0, overflow}, 36'd0);
        chk("rst_full", {35'h0, full}, 36'd0);

        // four pixels -> one full word, popped right away
        cyc(1, 8'h11, 0, 1, 0, 0);
        cyc(1, 8'h22, 0, 1, 0, 0);
        cyc(1, 8'h33, 0, 1, 0, 0);
        cyc(1, 8'h44, 0, 1, 0, 0);
        cyc(0, 8'h00, 0, 1, 0, 0);
        #2;
        chk("w1_valid", {35'h0, word_valid}, 36'd1);
        chk("w1_data", {word_keep, word_out}, {4'hF, 32'h44332211});
        cyc(0, 8'h00, 0, 1, 0, 0);
        #2;
        chk("w1_count_after_pop", 36'(count), 36'd0);

        // two pixels then flush; then a no-op flush with lane 0
        cyc(1, 8'hAA, 0, 0, 0, 0);
        cyc(1, 8'hBB, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        chk("fl2_data", {word_keep, word_out}, {4'h3, 32'h0000BBAA});
        chk("fl2_count", 36'(count), 36'd1);
        cyc(0, 8'h00, 1, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        chk("fl0_count", 36'(count), 36'd0);

        // fill the FIFO with 64 pixels, no draining
        for (int i = 0; i < 64; i++) cyc(1, 8'(i + 1), 0, 0, 0, 0);
        cyc(1, 8'h41, 0, 0, 0, 0);
        #2;
        chk("fill_count", 36'(count), 36'd16);
        chk("fill_full", {35'h0, full}, 36'd1);
        cyc(1, 8'h42, 0, 0, 0, 0);
        cyc(1, 8'h43, 0, 0, 0, 0);
        cyc(1, 8'h44, 0, 0, 0, 0);
        #2;
        chk("lane3_full_ready", {35'h0, pix_ready}, 36'd0);
        cyc(1, 8'h45, 0, 1, 0, 0);
        #2;
        chk("drop_ovf", {35'h0, overflow}, 36'd1);
        chk("pop_frees_ready", {35'h0, pix_ready}, 36'd1);
        cyc(0, 8'h00, 0, 0, 1, 0);
        #2;
        chk("pop_push_count", 36'(count), 36'd16);
        cyc(1, 8'h70, 0, 0, 0, 0);
        #2;
        chk("clr_ovf", {35'h0, overflow}, 36'd0);
        cyc(1, 8'h71, 0, 0, 0, 0);

        // flush while full with two lanes filled -> deferred
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        chk("pend_ready", {35'h0, pix_ready}, 36'd0);
        cyc(0, 8'h00, 0, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        chk("pend_count", 36'(count), 36'd16);
        chk("pend_cleared_ready", {35'h0, pix_ready}, 36'd1);
        repeat (15) cyc(0, 8'h00, 0, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        chk("pend_word", {word_keep, word_out}, {4'h3, 32'h00007170});
        chk("pend_last_count", 36'(count), 36'd1);
        cyc(0, 8'h00, 0, 1, 0, 0);

        // stored word plus partial word, then reset
        cyc(1, 8'hEF, 0, 0, 0, 0);
        cyc(1, 8'hBE, 0, 0, 0, 0);
        cyc(1, 8'hAD, 0, 0, 0, 0);
        cyc(1, 8'hDE, 0, 0, 0, 0);
        cyc(1, 8'h01, 0, 0, 0, 0);
        cyc(1, 8'h02, 0, 0, 0, 0);
        cyc(1, 8'h03, 0, 0, 0, 0);
        #2;
        chk("pre_rst_count", 36'(count), 36'd1);
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(1, 8'h05, 0, 0, 0, 0);
        #2;
        chk("mid_rst_count", 36'(count), 36'd0);
        chk("mid_rst_valid", {35'h0, word_valid}, 36'd0);
        chk("mid_rst_ovf", {35'h0, overflow}, 36'd0);
        cyc(1, 8'h06, 0, 0, 0, 0);
        cyc(1, 8'h07, 0, 0, 0, 0);
        cyc(1, 8'h08, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        chk("post_rst_word", {word_keep, word_out}, {4'hF, 32'h08070605});

        // flush on the same cycle as the third pixel
        cyc(1, 8'hAA, 0, 1, 0, 0);
        cyc(1, 8'hBB, 0, 0, 0, 0);
        cyc(1, 8'hCC, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        chk("fl3_word", {word_keep, word_out}, {4'h7, 32'h00CCBBAA});
        chk("fl3_count", 36'(count), 36'd1);

        // flush on the fourth pixel -> exactly one full word
        cyc(1, 8'hDD, 0, 1, 0, 0);
        cyc(1, 8'hEE, 0, 0, 0, 0);
        cyc(1, 8'hFF, 0, 0, 0, 0);
        cyc(1, 8'h12, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        chk("fl4_word", {word_keep, word_out}, {4'hF, 32'h12FFEEDD});
        cyc(0, 8'h00, 0, 0, 0, 0);
        #2;
        chk("fl4_count", 36'(count), 36'd1);

        repeat (3) cyc(0, 8'h00, 0, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
